// File: rtl/anim_pkg.sv
// rtl/anim_pkg.sv - shared constants and state type for the animation sequencer
// Contents:
//   ANIM_AW      default width of animation index, frame counter and limit
//   ANIM_NUM     default number of valid animations
//   ANIM_LAST    default wrap value (ANIM_NUM-1)
//   ANIM_REPEATS default completed loops before auto-advance
//   state_t      sequencer FSM states
package anim_pkg;
   localparam int ANIM_AW      = 6;
   localparam int ANIM_NUM     = 56;
   localparam int ANIM_LAST    = ANIM_NUM - 1;
   localparam int ANIM_REPEATS = 2;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_PAUSE,
      ST_SWITCH
   } state_t;
endpackage

// File: rtl/anim_index_step.sv
// rtl/anim_index_step.sv - combinational next/prev/load index selection with wrap
// Ports:
//   cur        in   current animation index
//   load_en    in   load request
//   load_anim  in   load target (ignored when out of range)
//   next_req   in   step forward request
//   prev_req   in   step backward request
//   inc_idx    out  cur+1 with wrap (also used for auto-advance)
//   sel_idx    out  index selected by the highest-priority valid request
//   sel_valid  out  a valid request selected sel_idx
module anim_index_step
   import anim_pkg::*;
#(
   parameter int AW       = ANIM_AW,
   parameter int NUM_ANIM = ANIM_NUM
) (
   input  logic [AW-1:0] cur,
   input  logic          load_en,
   input  logic [AW-1:0] load_anim,
   input  logic          next_req,
   input  logic          prev_req,
   output logic [AW-1:0] inc_idx,
   output logic [AW-1:0] sel_idx,
   output logic          sel_valid
);
   localparam logic [AW-1:0] LAST = AW'(NUM_ANIM - 1);

   logic [AW-1:0] dec_idx;
   logic          load_ok;

   always_comb begin
      inc_idx   = (cur == LAST) ? '0 : cur + AW'(1);
      dec_idx   = (cur == '0) ? LAST : cur - AW'(1);
      // Extra bit keeps the range check correct even if NUM_ANIM == 2**AW.
      load_ok   = load_en && ({1'b0, load_anim} < (AW+1)'(NUM_ANIM));
      sel_idx   = cur;
      sel_valid = 1'b0;
      // An out-of-range load falls through so next/prev in the same cycle still apply.
      if (load_ok) begin
         sel_idx   = load_anim;
         sel_valid = 1'b1;
      end else if (next_req) begin
         sel_idx   = inc_idx;
         sel_valid = 1'b1;
      end else if (prev_req) begin
         sel_idx   = dec_idx;
         sel_valid = 1'b1;
      end
   end
endmodule

// File: rtl/animation_sequencer.sv
// rtl/animation_sequencer.sv - frame/loop counter and animation selection FSM
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   tick                frame-step enable from prescaler
//   limit               frame count of current animation (lookup of animation)
//   auto_en             advance after REPEATS completed loops
//   pause               level, freezes frame stepping
//   next_req, prev_req  step animation forward/backward
//   load_en, load_anim  jump to load_anim (ignored when out of range)
//   animation, frame    current animation index and frame
//   loop_cnt            completed loops of current animation (saturating)
//   frame_stb           pulse: frame or animation changed
//   anim_stb            pulse: animation changed
module animation_sequencer
   import anim_pkg::*;
#(
   parameter int NUM_ANIM = ANIM_NUM,
   parameter int REPEATS  = ANIM_REPEATS,
   parameter int AW       = ANIM_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic [AW-1:0] limit,
   input  logic          auto_en,
   input  logic          pause,
   input  logic          next_req,
   input  logic          prev_req,
   input  logic          load_en,
   input  logic [AW-1:0] load_anim,
   output logic [AW-1:0] animation,
   output logic [AW-1:0] frame,
   output logic [AW-1:0] loop_cnt,
   output logic          frame_stb,
   output logic          anim_stb
);
   state_t        state;
   logic [AW-1:0] eff_limit;
   logic          at_wrap;
   logic          last_loop;
   logic [AW-1:0] inc_idx;
   logic [AW-1:0] sel_idx;
   logic          sel_valid;

   anim_index_step #(.AW(AW), .NUM_ANIM(NUM_ANIM)) u_step (
      .cur       (animation),
      .load_en   (load_en),
      .load_anim (load_anim),
      .next_req  (next_req),
      .prev_req  (prev_req),
      .inc_idx   (inc_idx),
      .sel_idx   (sel_idx),
      .sel_valid (sel_valid)
   );

   // A zero limit is treated as a single-frame animation.
   assign eff_limit = (limit == '0) ? AW'(1) : limit;
   // >= rather than == so a frame left beyond a shrunken limit wraps instead of counting on.
   assign at_wrap   = (frame >= eff_limit - AW'(1));
   assign last_loop = (loop_cnt == AW'(REPEATS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_RUN;
         animation <= '0;
         frame     <= '0;
         loop_cnt  <= '0;
         frame_stb <= 1'b0;
         anim_stb  <= 1'b0;
      end else begin
         frame_stb <= 1'b0;
         anim_stb  <= 1'b0;
         if (state == ST_SWITCH) begin
            // Settle cycle: the limit lookup sees the new index before it is used.
            frame    <= '0;
            loop_cnt <= '0;
            state    <= pause ? ST_PAUSE : ST_RUN;
         end else begin
            state <= pause ? ST_PAUSE : ST_RUN;
            if (sel_valid) begin
               animation <= sel_idx;
               frame     <= '0;
               loop_cnt  <= '0;
               frame_stb <= 1'b1;
               anim_stb  <= 1'b1;
               state     <= ST_SWITCH;
            end else if (state == ST_RUN && tick) begin
               frame_stb <= 1'b1;
               if (at_wrap) begin
                  frame <= '0;
                  if (auto_en && last_loop) begin
                     animation <= inc_idx;
                     loop_cnt  <= '0;
                     anim_stb  <= 1'b1;
                     state     <= ST_SWITCH;
                  end else if (loop_cnt != '1) begin
                     loop_cnt <= loop_cnt + AW'(1);
                  end
               end else begin
                  frame <= frame + AW'(1);
               end
            end
         end
      end
   end
endmodule
